// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ---------------------------------------------------------------------------
// ID/EX pipeline register plus the execute-side operand select and
// forwarding that feeds the ALU directly.
//
// Decoded fields are captured on one rising edge of CLK. portA, portB,
// ex_stdat and the pass-through control bits are then formed combinationally
// from the captured fields. When forwarding is built in, they also depend on
// the live EX/MEM and MEM/WB write-back ports.
//
// Optional feature macro: ID_EX_FORWARD_EN
//   defined   : rs and rt are forwarded from EX/MEM (highest priority) or
//               MEM/WB when the destination index matches and is non-zero.
//   undefined : no forwarding muxes. The operands use the latched register
//               file data only, and the exm_* / wb_* ports are ignored.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   stall, flush        hold the stage / load a bubble (flush beats stall)
//   id_*                decoded instruction fields from the ID stage
//   exm_*, wb_*         write-back ports of EX/MEM and MEM/WB (forwarding)
//   portA, portB, aluop ALU operands and operation
//   ex_valid, ex_wsel,
//   ex_regwr, ex_memrd,
//   ex_memwr            latched qualifiers for downstream stages
//   ex_stdat            forwarded rt, used as the store data
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [15:0]       id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_aluop,
  input  logic              id_asel,
  input  logic [1:0]        id_bsel,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_wsel,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              id_memwr,
  input  logic              exm_regwr,
  input  logic [REG_W-1:0]  exm_wsel,
  input  logic [WORD_W-1:0] exm_wdat,
  input  logic              wb_regwr,
  input  logic [REG_W-1:0]  wb_wsel,
  input  logic [WORD_W-1:0] wb_wdat,
  output logic [WORD_W-1:0] portA,
  output logic [WORD_W-1:0] portB,
  output logic [3:0]        aluop,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_wsel,
  output logic              ex_regwr,
  output logic              ex_memrd,
  output logic              ex_memwr,
  output logic [WORD_W-1:0] ex_stdat
);

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] rdat1;
    logic [WORD_W-1:0] rdat2;
    logic [15:0]       imm;
    logic [4:0]        shamt;
    logic [3:0]        aluop;
    logic              asel;
    logic [1:0]        bsel;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  wsel;
    logic              regwr;
    logic              memrd;
    logic              memwr;
  } stage_t;

  stage_t stage_d;
  stage_t stage_q;

  // Next-state: flush inserts an all-zero bubble, stall holds, otherwise load.
  // A non-valid slot still captures its fields, but must never commit state,
  // so valid, regwr and memwr are forced low. memrd only qualifies a read.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid = id_valid;
      stage_d.rdat1 = id_rdat1;
      stage_d.rdat2 = id_rdat2;
      stage_d.imm   = id_imm;
      stage_d.shamt = id_shamt;
      stage_d.aluop = id_aluop;
      stage_d.asel  = id_asel;
      stage_d.bsel  = id_bsel;
      stage_d.rs    = id_rs;
      stage_d.rt    = id_rt;
      stage_d.wsel  = id_wsel;
      stage_d.regwr = id_regwr & id_valid;
      stage_d.memrd = id_memrd;
      stage_d.memwr = id_memwr & id_valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Source operands: index 0 is rs, index 1 is rt.
  logic [REG_W-1:0]  src_idx [2];
  logic [WORD_W-1:0] src_lat [2];
  logic [WORD_W-1:0] src_fwd [2];

  assign src_idx[0] = stage_q.rs;
  assign src_idx[1] = stage_q.rt;
  assign src_lat[0] = stage_q.rdat1;
  assign src_lat[1] = stage_q.rdat2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ID_EX_FORWARD_EN
      // The younger EX/MEM result wins over MEM/WB. Register 0 is hard-wired
      // and never takes a forwarded value.
      logic exm_hit;
      logic wb_hit;
      assign exm_hit = exm_regwr && (exm_wsel == src_idx[gi]) && (src_idx[gi] != '0);
      assign wb_hit  = wb_regwr  && (wb_wsel  == src_idx[gi]) && (src_idx[gi] != '0);
      assign src_fwd[gi] = exm_hit ? exm_wdat :
                           wb_hit  ? wb_wdat  :
                                     src_lat[gi];
`else
      assign src_fwd[gi] = src_lat[gi];
`endif
    end
  endgenerate

`ifndef ID_EX_FORWARD_EN
  // The forwarding ports and latched source indices have no consumer here.
  logic unused_fwd;
  assign unused_fwd = ^{exm_regwr, exm_wsel, exm_wdat, wb_regwr, wb_wsel, wb_wdat,
                        src_idx[0], src_idx[1]};
`endif

  // Shift instructions carry the shift amount on portA.
  assign portA = stage_q.asel ? {{(WORD_W-5){1'b0}}, stage_q.shamt} : src_fwd[0];

  always_comb begin
    portB = src_fwd[1];
    unique case (stage_q.bsel)
      2'b00: portB = src_fwd[1];
      2'b01: portB = {{(WORD_W-16){stage_q.imm[15]}}, stage_q.imm};
      2'b10: portB = {{(WORD_W-16){1'b0}}, stage_q.imm};
      2'b11: portB = {{(WORD_W-32){1'b0}}, stage_q.imm, 16'h0000};
      default: portB = src_fwd[1];
    endcase
  end

  // Store data always follows rt, whatever operand B is selecting.
  assign ex_stdat = src_fwd[1];
  assign aluop    = stage_q.aluop;
  assign ex_valid = stage_q.valid;
  assign ex_wsel  = stage_q.wsel;
  assign ex_regwr = stage_q.regwr;
  assign ex_memrd = stage_q.memrd;
  assign ex_memwr = stage_q.memwr;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: table-driven vectors, hand-written
// stall/flush/reset sequences, and randomized stimulus against a
// behavioural model.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [3:0] OP_SLL = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;

  logic        CLK = 1'b0;
  logic        RST, stall, flush, id_valid;
  logic [31:0] id_rdat1, id_rdat2;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_aluop;
  logic        id_asel;
  logic [1:0]  id_bsel;
  logic [4:0]  id_rs, id_rt, id_wsel;
  logic        id_regwr, id_memrd, id_memwr;
  logic        exm_regwr;
  logic [4:0]  exm_wsel;
  logic [31:0] exm_wdat;
  logic        wb_regwr;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic [31:0] portA, portB, ex_stdat;
  logic [3:0]  aluop;
  logic        ex_valid, ex_regwr, ex_memrd, ex_memwr;
  logic [4:0]  ex_wsel;

  id_ex_operand_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_aluop(id_aluop),
    .id_asel(id_asel), .id_bsel(id_bsel), .id_rs(id_rs), .id_rt(id_rt),
    .id_wsel(id_wsel), .id_regwr(id_regwr), .id_memrd(id_memrd),
    .id_memwr(id_memwr), .exm_regwr(exm_regwr), .exm_wsel(exm_wsel),
    .exm_wdat(exm_wdat), .wb_regwr(wb_regwr), .wb_wsel(wb_wsel),
    .wb_wdat(wb_wdat), .portA(portA), .portB(portB), .aluop(aluop),
    .ex_valid(ex_valid), .ex_wsel(ex_wsel), .ex_regwr(ex_regwr),
    .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_stdat(ex_stdat)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [3:0]  aluop;
    logic        asel;
    logic [1:0]  bsel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wsel;
    logic        regwr;
    logic        memrd;
    logic        memwr;
  } id_t;

  typedef struct packed {
    logic        exm_regwr;
    logic [4:0]  exm_wsel;
    logic [31:0] exm_wdat;
    logic        wb_regwr;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
  } fw_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic        v;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  op;
    logic [4:0]  ws;
  } exp_t;

  typedef struct {
    id_t  id;
    fw_t  fw;
    exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".portA"},    portA,           e.a);
    chk({tag, ".portB"},    portB,           e.b);
    chk({tag, ".ex_stdat"}, ex_stdat,        e.st);
    chk({tag, ".ex_valid"}, 32'(ex_valid),   32'(e.v));
    chk({tag, ".ex_regwr"}, 32'(ex_regwr),   32'(e.rw));
    chk({tag, ".ex_memrd"}, 32'(ex_memrd),   32'(e.mr));
    chk({tag, ".ex_memwr"}, 32'(ex_memwr),   32'(e.mw));
    chk({tag, ".aluop"},    32'(aluop),      32'(e.op));
    chk({tag, ".ex_wsel"},  32'(ex_wsel),    32'(e.ws));
    $display("txn %s: portA=%h portB=%h stdat=%h valid=%0b aluop=%0d", tag, portA, portB,
             ex_stdat, ex_valid, aluop);
  endtask

  task automatic drive_id(input id_t t);
    id_valid = t.valid;  id_rdat1 = t.rdat1; id_rdat2 = t.rdat2;
    id_imm   = t.imm;    id_shamt = t.shamt; id_aluop = t.aluop;
    id_asel  = t.asel;   id_bsel  = t.bsel;  id_rs    = t.rs;
    id_rt    = t.rt;     id_wsel  = t.wsel;  id_regwr = t.regwr;
    id_memrd = t.memrd;  id_memwr = t.memwr;
  endtask

  task automatic drive_fw(input fw_t f);
    exm_regwr = f.exm_regwr; exm_wsel = f.exm_wsel; exm_wdat = f.exm_wdat;
    wb_regwr  = f.wb_regwr;  wb_wsel  = f.wb_wsel;  wb_wdat  = f.wb_wdat;
  endtask

  function automatic id_t mk_id(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [15:0] imm, input logic [4:0] sh, input logic [3:0] op,
                                input logic as, input logic [1:0] bs, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] ws, input logic rw,
                                input logic mr, input logic mw);
    id_t t;
    t.valid = v; t.rdat1 = r1; t.rdat2 = r2; t.imm = imm; t.shamt = sh; t.aluop = op;
    t.asel = as; t.bsel = bs; t.rs = rs; t.rt = rt; t.wsel = ws;
    t.regwr = rw; t.memrd = mr; t.memwr = mw;
    return t;
  endfunction

  function automatic fw_t mk_fw(input logic er, input logic [4:0] ew, input logic [31:0] ed,
                                input logic wr, input logic [4:0] ww, input logic [31:0] wd);
    fw_t f;
    f.exm_regwr = er; f.exm_wsel = ew; f.exm_wdat = ed;
    f.wb_regwr = wr;  f.wb_wsel = ww;  f.wb_wdat = wd;
    return f;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                                  input logic v, input logic rw, input logic mr, input logic mw,
                                  input logic [3:0] op, input logic [4:0] ws);
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.op = op; e.ws = ws;
    return e;
  endfunction

  // ---------------- behavioural reference model ----------------
  // What a captured instruction looks like: a non-valid slot never writes.
  function automatic id_t capture(input id_t in);
    id_t t = in;
    if (!in.valid) begin
      t.regwr = 1'b0;
      t.memwr = 1'b0;
    end
    return t;
  endfunction

  // Value of register r as seen by EX: the newest in-flight write wins.
  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf,
                                            input fw_t f);
    if (!FWD || r == 5'd0) return rf;
    if (f.exm_regwr && f.exm_wsel == r) return f.exm_wdat;
    if (f.wb_regwr && f.wb_wsel == r) return f.wb_wdat;
    return rf;
  endfunction

  function automatic exp_t model(input id_t m, input fw_t f);
    exp_t e;
    int   simm;
    logic [31:0] rs_v, rt_v;
    rs_v = reg_value(m.rs, m.rdat1, f);
    rt_v = reg_value(m.rt, m.rdat2, f);
    simm = int'($signed(m.imm));
    e.a  = m.asel ? 32'(m.shamt) : rs_v;
    case (m.bsel)
      2'd0: e.b = rt_v;
      2'd1: e.b = 32'(simm);
      2'd2: e.b = 32'(m.imm);
      default: e.b = 32'(m.imm) * 32'd65536;
    endcase
    e.st = rt_v;
    e.v = m.valid; e.rw = m.regwr; e.mr = m.memrd; e.mw = m.memwr;
    e.op = m.aluop; e.ws = m.wsel;
    return e;
  endfunction

  function automatic id_t rand_id();
    id_t t;
    t.valid = ($urandom_range(0, 3) != 0);
    t.rdat1 = $urandom; t.rdat2 = $urandom;
    t.imm = 16'($urandom); t.shamt = 5'($urandom); t.aluop = 4'($urandom);
    t.asel = 1'($urandom); t.bsel = 2'($urandom);
    t.rs = 5'($urandom_range(0, 3)); t.rt = 5'($urandom_range(0, 3));
    t.wsel = 5'($urandom);
    t.regwr = 1'($urandom); t.memrd = 1'($urandom); t.memwr = 1'($urandom);
    return t;
  endfunction

  function automatic fw_t rand_fw();
    return mk_fw(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
  endfunction

  vec_t vecs[11];
  id_t  m;
  fw_t  fw;
  id_t  in;

  initial begin
    id_t  id_a, id_b;
    exp_t exp_a, zero_e;
    fw_t  no_fw;
    logic [31:0] a1, a2, st9, b10;

    no_fw  = '0;
    zero_e = '0;
    id_a   = mk_id(1, 32'd5, 32'd7, 16'h0, 5'd0, OP_ADD, 0, 2'b00, 5'd1, 5'd2, 5'd4, 1, 0, 0);
    id_b   = mk_id(1, 32'h99, 32'h1, 16'h0, 5'd4, OP_SLL, 1, 2'b00, 5'd7, 5'd8, 5'd9, 1, 0, 0);
    exp_a  = mk_exp(32'd5, 32'd7, 32'd7, 1, 1, 0, 0, OP_ADD, 5'd4);

    a1  = FWD ? 32'hAA : 32'h11;
    a2  = FWD ? 32'hBB : 32'h11;
    st9 = FWD ? 32'hCC : 32'h9;
    b10 = FWD ? 32'hDD : 32'h9;

    vecs[0] = '{id_a, no_fw, exp_a};
    vecs[1] = '{mk_id(1, 32'h11, 32'h22, 16'h0, 5'd0, OP_ADD, 0, 2'b00, 5'd3, 5'd2, 5'd5, 1, 0, 0),
                mk_fw(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB),
                mk_exp(a1, 32'h22, 32'h22, 1, 1, 0, 0, OP_ADD, 5'd5)};
    vecs[2] = '{vecs[1].id, mk_fw(0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB),
                mk_exp(a2, 32'h22, 32'h22, 1, 1, 0, 0, OP_ADD, 5'd5)};
    vecs[3] = '{mk_id(1, 32'h11, 32'h22, 16'h0, 5'd0, OP_ADD, 0, 2'b00, 5'd0, 5'd2, 5'd5, 1, 0, 0),
                mk_fw(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB),
                mk_exp(32'h11, 32'h22, 32'h22, 1, 1, 0, 0, OP_ADD, 5'd5)};
    vecs[4] = '{id_b, no_fw, mk_exp(32'h4, 32'h1, 32'h1, 1, 1, 0, 0, OP_SLL, 5'd9)};
    vecs[5] = '{mk_id(1, 32'h99, 32'h1, 16'h8000, 5'd4, OP_SLL, 1, 2'b01, 5'd7, 5'd8, 5'd9, 1, 0, 0),
                no_fw, mk_exp(32'h4, 32'hFFFF8000, 32'h1, 1, 1, 0, 0, OP_SLL, 5'd9)};
    vecs[6] = '{mk_id(1, 32'h99, 32'h1, 16'h8000, 5'd4, OP_SLL, 1, 2'b10, 5'd7, 5'd8, 5'd9, 1, 0, 0),
                no_fw, mk_exp(32'h4, 32'h00008000, 32'h1, 1, 1, 0, 0, OP_SLL, 5'd9)};
    vecs[7] = '{mk_id(1, 32'h99, 32'h1, 16'h1234, 5'd4, OP_SLL, 1, 2'b11, 5'd7, 5'd8, 5'd9, 1, 0, 0),
                no_fw, mk_exp(32'h4, 32'h12340000, 32'h1, 1, 1, 0, 0, OP_SLL, 5'd9)};
    vecs[8] = '{mk_id(0, 32'h3, 32'h4, 16'h0, 5'd0, OP_SUB, 0, 2'b00, 5'd1, 5'd2, 5'd3, 1, 1, 1),
                no_fw, mk_exp(32'h3, 32'h4, 32'h4, 0, 0, 1, 0, OP_SUB, 5'd3)};
    vecs[9] = '{mk_id(1, 32'h1, 32'h9, 16'h00F0, 5'd0, OP_ADD, 0, 2'b01, 5'd1, 5'd6, 5'd6, 0, 0, 1),
                mk_fw(1, 5'd6, 32'hCC, 1, 5'd6, 32'hDD),
                mk_exp(32'h1, 32'hF0, st9, 1, 0, 0, 1, OP_ADD, 5'd6)};
    vecs[10] = '{mk_id(1, 32'h1, 32'h9, 16'h00F0, 5'd0, OP_ADD, 0, 2'b00, 5'd1, 5'd6, 5'd6, 0, 0, 1),
                 mk_fw(0, 5'd6, 32'hCC, 1, 5'd6, 32'hDD),
                 mk_exp(32'h1, b10, b10, 1, 0, 0, 1, OP_ADD, 5'd6)};

    // Reset held for two edges while a valid instruction is presented.
    RST = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(id_a); drive_fw(no_fw);
    repeat (2) @(posedge CLK);
    #1 check_out("reset", zero_e);
    RST = 1'b0;

    // Table-driven single-instruction vectors.
    for (int i = 0; i < 11; i++) begin
      drive_id(vecs[i].id);
      drive_fw(vecs[i].fw);
      @(posedge CLK);
      #1 check_out($sformatf("vec%0d", i), vecs[i].e);
    end

    // Stall holds A for three edges while decode keeps changing.
    drive_fw(no_fw);
    drive_id(id_a);
    @(posedge CLK);
    #1 check_out("stall_load", exp_a);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(rand_id());
      @(posedge CLK);
      #1 check_out($sformatf("stall_hold%0d", i), exp_a);
    end
    stall = 1'b0;

    // flush together with stall: bubble wins.
    drive_id(id_a);
    @(posedge CLK);
    #1 stall = 1'b1; flush = 1'b1; drive_id(id_b);
    @(posedge CLK);
    #1 check_out("stall_flush", zero_e);
    stall = 1'b0; flush = 1'b0;

    // Reset during a stall still clears.
    drive_id(id_a);
    @(posedge CLK);
    #1 check_out("pre_rst_stall", exp_a);
    stall = 1'b1; RST = 1'b1;
    @(posedge CLK);
    #1 check_out("rst_stall", zero_e);
    stall = 1'b0; RST = 1'b0;

    // Flush alone.
    drive_id(id_b);
    @(posedge CLK);
    #1 flush = 1'b1; drive_id(id_a);
    @(posedge CLK);
    #1 check_out("flush", zero_e);
    flush = 1'b0;

    // Randomized traffic against the behavioural model.
    RST = 1'b1;
    @(posedge CLK);
    #1 m = '0;
    RST = 1'b0;
    for (int i = 0; i < 400; i++) begin
      in    = rand_id();
      fw    = rand_fw();
      RST   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 3) == 0);
      drive_id(in);
      drive_fw(fw);
      @(posedge CLK);
      if (RST || flush) m = '0;
      else if (!stall) m = capture(in);
      #1 check_out($sformatf("rnd%0d", i), model(m, fw));
      // Forwarding inputs may move while the stage holds its contents.
      fw = rand_fw();
      drive_fw(fw);
      #1 check_out($sformatf("rnd%0d_fw", i), model(m, fw));
    end
    RST = 1'b0; stall = 1'b0; flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
